// File: rtl/inc_arbiter.sv
// Round-robin arbiter that time-shares one external WIDTH-bit incrementer
// between NREQ requesters (PC advance, ISZ, auto-index) and returns results.
module inc_arbiter #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 12
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ*WIDTH-1:0]   DIN,
  input  logic [NREQ-1:0]         OPINC,
  output logic [NREQ-1:0]         GNT,
  output logic [NREQ-1:0]         DONE,
  output logic [WIDTH-1:0]        RESULT,
  output logic                    CARRY,
  output logic                    ZERO,
  output logic [WIDTH-1:0]        INC_IN,
  output logic                    INC_EN,
  output logic                    INC_OE,
  input  logic [WIDTH-1:0]        INC_OUT,
  input  logic                    INC_C
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: REQ[i] is a level held with DIN/OPINC stable until GNT[i]
  // pulses; the result is valid in the single cycle DONE[i] is high.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PW-1:0]     last;
  logic [PW-1:0]     win;
  logic              found;
  logic [WIDTH-1:0]  opnd;
  logic              mode;

  // Winner search starts just above the last grant and wraps.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = RUN;
      RUN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The incrementer is only driven during RUN so its output is released otherwise.
  always_comb begin
    INC_IN = '0;
    INC_EN = 1'b0;
    INC_OE = 1'b0;
    if (state == RUN) begin
      INC_IN = opnd;
      INC_EN = mode;
      INC_OE = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      last   <= PW'(NREQ - 1);
      GNT    <= '0;
      DONE   <= '0;
      RESULT <= '0;
      CARRY  <= 1'b0;
      ZERO   <= 1'b0;
      opnd   <= '0;
      mode   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          DONE <= '0;
          if (found) begin
            GNT  <= NREQ'(1) << win;
            opnd <= DIN[int'(win)*WIDTH +: WIDTH];
            mode <= OPINC[win];
            last <= win;
          end
        end
        RUN: begin
          RESULT <= INC_OUT;
          CARRY  <= INC_C;
          ZERO   <= (INC_OUT == '0);
          // GNT still holds the winner's one-hot code during RUN.
          DONE   <= GNT;
          GNT    <= '0;
        end
        default: begin
          GNT  <= '0;
          DONE <= '0;
        end
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge CLK) disable iff (RESET) $onehot0(GNT));
  a_done_onehot: assert property (@(posedge CLK) disable iff (RESET) $onehot0(DONE));
  a_gnt_done_excl: assert property (@(posedge CLK) disable iff (RESET) !((|GNT) && (|DONE)));

endmodule

// File: tb/tb_inc_arbiter.sv
// Directed bench for inc_arbiter: drivers push expected grants/results into
// queues, a negedge monitor pops and compares whenever GNT or DONE fires.
module tb_inc_arbiter;
  localparam int NREQ  = 3;
  localparam int WIDTH = 12;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       opinc;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  carry;
  logic                  zero;
  logic [WIDTH-1:0]      inc_in;
  logic                  inc_en;
  logic                  inc_oe;
  logic [WIDTH-1:0]      inc_out;
  logic                  inc_c;

  int tests = 0;
  int fails = 0;

  logic [NREQ+WIDTH+1:0] exp_q[$];
  logic [NREQ-1:0]       gnt_q[$];

  inc_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK(clk), .RESET(rst), .REQ(req), .DIN(din), .OPINC(opinc),
    .GNT(gnt), .DONE(done), .RESULT(result), .CARRY(carry), .ZERO(zero),
    .INC_IN(inc_in), .INC_EN(inc_en), .INC_OE(inc_oe),
    .INC_OUT(inc_out), .INC_C(inc_c)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // External incrementer model
  always_comb begin
    inc_out = '0;
    inc_c   = 1'b0;
    if (inc_oe) begin
      inc_out = inc_en ? inc_in + 1'b1 : inc_in;
      inc_c   = inc_en & (&inc_in);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [NREQ+WIDTH+1:0] e;
    check("gnt_done_excl", {31'd0, (|gnt) & (|done)}, 32'd0);
    if (gnt != 0) begin
      if (gnt_q.size() == 0) check("unexpected_gnt", {29'd0, gnt}, 32'd0);
      else check("gnt_order", {29'd0, gnt}, {29'd0, gnt_q.pop_front()});
    end
    if (done != 0) begin
      if (exp_q.size() == 0) check("unexpected_done", {29'd0, done}, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("done_onehot", {29'd0, done}, {29'd0, e[NREQ+WIDTH+1:WIDTH+2]});
        check("result", {20'd0, result}, {20'd0, e[WIDTH+1:2]});
        check("carry", {31'd0, carry}, {31'd0, e[1]});
        check("zero", {31'd0, zero}, {31'd0, e[0]});
      end
    end
  end

  // Driver tasks
  task automatic set_op(input int i, input logic [WIDTH-1:0] d, input logic o);
    din[i*WIDTH +: WIDTH] = d;
    opinc[i] = o;
  endtask

  task automatic push(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] r,
                      input logic c, input logic z);
    gnt_q.push_back(g);
    exp_q.push_back({g, r, c, z});
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (gnt != 0) break;
      if (n >= 20) begin
        tests++;
        fails++;
        $display("FAIL gnt_timeout: got no grant expected one within 20 cycles");
        break;
      end
    end
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got time limit expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    req = '0;
    din = '0;
    opinc = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", {29'd0, gnt}, 32'd0);
    check("rst_done", {29'd0, done}, 32'd0);
    check("rst_result", {20'd0, result}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_inc_in", {20'd0, inc_in}, 32'd0);
    check("rst_inc_en", {31'd0, inc_en}, 32'd0);
    check("rst_inc_oe", {31'd0, inc_oe}, 32'd0);
    rst = 1'b0;

    repeat (10) begin
      @(negedge clk);
      check("idle_inc_oe", {31'd0, inc_oe}, 32'd0);
      check("idle_gnt", {29'd0, gnt}, 32'd0);
    end

    // Single increment on PC
    set_op(0, 12'h123, 1'b1);
    push(3'b001, 12'h124, 1'b0, 1'b0);
    req = 3'b001;
    wait_gnt(n);
    check("gnt_latency", n, 32'd1);
    req = '0;
    repeat (2) @(negedge clk);

    // ISZ wrap
    set_op(1, 12'hFFF, 1'b1);
    push(3'b010, 12'h000, 1'b1, 1'b1);
    req = 3'b010;
    wait_gnt(n);
    req = '0;
    repeat (2) @(negedge clk);

    // Auto-index pass-through
    set_op(2, 12'h000, 1'b0);
    push(3'b100, 12'h000, 1'b0, 1'b1);
    req = 3'b100;
    wait_gnt(n);
    check("pt_inc_en", {31'd0, inc_en}, 32'd0);
    check("pt_inc_oe", {31'd0, inc_oe}, 32'd1);
    req = '0;
    repeat (2) @(negedge clk);

    // Contention, all three held
    set_op(0, 12'h010, 1'b1);
    set_op(1, 12'h020, 1'b1);
    set_op(2, 12'h030, 1'b1);
    push(3'b001, 12'h011, 1'b0, 1'b0);
    push(3'b010, 12'h021, 1'b0, 1'b0);
    push(3'b100, 12'h031, 1'b0, 1'b0);
    push(3'b001, 12'h011, 1'b0, 1'b0);
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(n);
      if (g > 0) check("gnt_spacing", n, 32'd2);
    end
    req = '0;
    repeat (2) @(negedge clk);

    // Reset during RUN with requester 0 in flight
    set_op(0, 12'h200, 1'b1);
    gnt_q.push_back(3'b001);
    req = 3'b001;
    wait_gnt(n);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("mid_rst_gnt", {29'd0, gnt}, 32'd0);
    check("mid_rst_done", {29'd0, done}, 32'd0);
    check("mid_rst_result", {20'd0, result}, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd0);
    check("mid_rst_inc_oe", {31'd0, inc_oe}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_no_done", {29'd0, done}, 32'd0);

    // Priority pointer must be back at requester 0
    set_op(0, 12'h7FE, 1'b1);
    set_op(1, 12'h100, 1'b0);
    push(3'b001, 12'h7FF, 1'b0, 1'b0);
    push(3'b010, 12'h100, 1'b0, 1'b0);
    req = 3'b011;
    wait_gnt(n);
    req = 3'b010;
    wait_gnt(n);
    check("post_rst_spacing", n, 32'd2);
    req = '0;
    repeat (3) @(negedge clk);

    check("exp_q_drained", exp_q.size(), 32'd0);
    check("gnt_q_drained", gnt_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
